// File: rtl/down_counter_timer.sv
// Loadable N-bit down-counter/timer with a programmable lower bound, a combinational bound flag and a done flag held until ack.
// Optional feature: define DOWN_COUNTER_AUTO_RELOAD_EN to restart from the last loaded value on ack.
module down_counter_timer #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [N-1:0] par_load,
  input  logic [N-1:0] lower_bound,
  input  logic         ack,
  input  logic         auto_reload,
  output logic [N-1:0] W,
  output logic         bo,
  output logic         busy,
  output logic         done,
  output logic [1:0]   o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [N-1:0] r_w;
  logic [N-1:0] w_next_w;
  logic         r_busy;
  logic         r_done;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [N-1:0] r_reload;
  logic [N-1:0] w_next_reload;
`else
  logic         w_unused_auto_reload;
  assign w_unused_auto_reload = auto_reload;
`endif

  // Next-state and next-count; priority is load, then ack, then en.
  always_comb begin
    w_next_state = r_state;
    w_next_w     = r_w;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    w_next_reload = r_reload;
`endif
    if (load) begin
      w_next_w     = par_load;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      w_next_reload = par_load;
`endif
      w_next_state = (par_load > lower_bound) ? S_RUN : S_DONE;
    end else begin
      case (r_state)
        S_RUN: begin
          if (en && (r_w > lower_bound)) begin
            w_next_w = r_w - 1'b1;
            if ((r_w - 1'b1) == lower_bound) w_next_state = S_DONE;
          end else if (r_w <= lower_bound) begin
            // Bound raised to or above the count mid-run: stop without touching W.
            w_next_state = S_DONE;
          end
        end
        S_DONE: begin
          if (ack) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            if (auto_reload) begin
              w_next_w     = r_reload;
              w_next_state = (r_reload > lower_bound) ? S_RUN : S_DONE;
            end else begin
              w_next_state = S_IDLE;
            end
`else
            w_next_state = S_IDLE;
`endif
          end
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_w     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      r_state <= w_next_state;
      r_w     <= w_next_w;
      r_busy  <= (w_next_state == S_RUN);
      r_done  <= (w_next_state == S_DONE);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      r_reload <= w_next_reload;
`endif
    end
  end

  assign W       = r_w;
  assign bo      = (r_w == lower_bound);
  assign busy    = r_busy;
  assign done    = r_done;
  assign o_state = r_state;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer; inputs change and outputs are sampled 1 ns after each rising edge.
module tb_down_counter_timer;

  localparam int N = 6;

  logic         clk;
  logic         reset;
  logic         load;
  logic         en;
  logic [N-1:0] par_load;
  logic [N-1:0] lower_bound;
  logic         ack;
  logic         auto_reload;
  logic [N-1:0] W;
  logic         bo;
  logic         busy;
  logic         done;
  logic [1:0]   o_state;

  int checks;
  int errors;

  down_counter_timer #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .en          (en),
    .par_load    (par_load),
    .lower_bound (lower_bound),
    .ack         (ack),
    .auto_reload (auto_reload),
    .W           (W),
    .bo          (bo),
    .busy        (busy),
    .done        (done),
    .o_state     (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    load = 0; en = 0; ack = 0; auto_reload = 0;
    par_load = '0; lower_bound = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (W !== 6'd0 || busy !== 1'b0 || done !== 1'b0 || o_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state W=%0d busy=%b done=%b st=%0d want 0 0 0 0", W, busy, done, o_state);
    end
    lower_bound = 6'd0; #1;
    checks++;
    if (bo !== 1'b1) begin errors++; $display("FAIL reset_bo_lb0 bo=%b want 1", bo); end
    lower_bound = 6'd3; #1;
    checks++;
    if (bo !== 1'b0) begin errors++; $display("FAIL reset_bo_lb3 bo=%b want 0", bo); end
  endtask

  task automatic test_countdown();
    do_reset();
    par_load = 6'd10; lower_bound = 6'd3; load = 1;
    tick();
    load = 0;
    checks++;
    if (W !== 6'd10 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL cd_load W=%0d busy=%b done=%b want 10 1 0", W, busy, done);
    end
    en = 1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (W !== 6'(10 - k) || done !== (k == 7) || busy !== (k != 7) || bo !== (k == 7)) begin
        errors++;
        $display("FAIL cd_step%0d W=%0d done=%b busy=%b bo=%b want %0d %b %b %b",
                 k, W, done, busy, bo, 10 - k, k == 7, k != 7, k == 7);
      end
    end
    tick();
    tick();
    checks++;
    if (W !== 6'd3 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cd_hold W=%0d done=%b busy=%b want 3 1 0", W, done, busy);
    end
    en = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    par_load = 6'd20; lower_bound = 6'd3; load = 1;
    tick();
    load = 0;
    checks++;
    if (W !== 6'd20 || busy !== 1'b1) begin
      errors++; $display("FAIL ar_load W=%0d busy=%b want 20 1", W, busy);
    end
    en = 1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (W !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ar_async W=%0d busy=%b done=%b want 0 0 0", W, busy, done);
    end
    #2 reset = 1'b1;
    tick();
    tick();
    checks++;
    if (W !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ar_after W=%0d busy=%b done=%b want 0 0 0", W, busy, done);
    end
    en = 0;
  endtask

  task automatic test_load_priority();
    do_reset();
    par_load = 6'd7; lower_bound = 6'd0; load = 1;
    tick();
    en = 1; par_load = 6'd15;
    tick();
    load = 0; en = 0;
    checks++;
    if (W !== 6'd15 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL lp_run W=%0d busy=%b done=%b want 15 1 0", W, busy, done);
    end
    par_load = 6'd3; lower_bound = 6'd3; load = 1;
    tick();
    load = 0;
    checks++;
    if (W !== 6'd3 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL lp_done W=%0d done=%b busy=%b want 3 1 0", W, done, busy);
    end
    par_load = 6'd9; load = 1; ack = 1;
    tick();
    load = 0; ack = 0;
    checks++;
    if (W !== 6'd9 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL lp_ack W=%0d busy=%b done=%b want 9 1 0", W, busy, done);
    end
  endtask

  task automatic test_bound_raise();
    do_reset();
    par_load = 6'd8; lower_bound = 6'd3; load = 1;
    tick();
    load = 0; en = 0;
    lower_bound = 6'd8; #1;
    checks++;
    if (bo !== 1'b1) begin errors++; $display("FAIL br_bo_comb bo=%b want 1", bo); end
    lower_bound = 6'd12;
    tick();
    checks++;
    if (W !== 6'd8 || done !== 1'b1 || busy !== 1'b0 || bo !== 1'b0) begin
      errors++; $display("FAIL br_done W=%0d done=%b busy=%b bo=%b want 8 1 0 0", W, done, busy, bo);
    end
    ack = 1;
    tick();
    ack = 0;
    checks++;
    if (W !== 6'd8 || done !== 1'b0 || busy !== 1'b0 || o_state !== 2'd0) begin
      errors++; $display("FAIL br_ack W=%0d done=%b busy=%b st=%0d want 8 0 0 0", W, done, busy, o_state);
    end
    lower_bound = 6'd0; en = 1; ack = 1;
    tick();
    en = 0; ack = 0;
    checks++;
    if (W !== 6'd8 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL br_idle W=%0d done=%b busy=%b want 8 0 0", W, done, busy);
    end
  endtask

  task automatic test_load_at_bound();
    do_reset();
    par_load = 6'd5; lower_bound = 6'd5; load = 1;
    tick();
    load = 0;
    checks++;
    if (W !== 6'd5 || done !== 1'b1 || bo !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL lab_load W=%0d done=%b bo=%b busy=%b want 5 1 1 0", W, done, bo, busy);
    end
    en = 1;
    tick();
    en = 0;
    checks++;
    if (W !== 6'd5 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL lab_hold W=%0d done=%b busy=%b want 5 1 0", W, done, busy);
    end
  endtask

  task automatic test_auto_reload();
    do_reset();
    par_load = 6'd5; lower_bound = 6'd0; load = 1;
    tick();
    load = 0; en = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (W !== 6'(5 - k) || done !== (k == 5)) begin
        errors++;
        $display("FAIL rl_step%0d W=%0d done=%b want %0d %b", k, W, done, 5 - k, k == 5);
      end
    end
    ack = 1; auto_reload = 1;
    tick();
    ack = 0; auto_reload = 0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    checks++;
    if (W !== 6'd5 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL rl_ack W=%0d busy=%b done=%b want 5 1 0", W, busy, done);
    end
`else
    checks++;
    if (W !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rl_ack W=%0d busy=%b done=%b want 0 0 0", W, busy, done);
    end
`endif
    en = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_countdown();
    test_async_reset();
    test_load_priority();
    test_bound_raise();
    test_load_at_bound();
    test_auto_reload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable N-bit down-counter/timer; the counting-down counterpart of the team's loadable up-counter with upper-bound carry-out.
- Counts from a parallel-loaded value down to a programmable lower bound.
- Flags the bound combinationally on bo; holds a registered done flag until the consumer acks it.
- Used as the countdown and timeout source in the lab TOP datapath.

Parameters:
- N, 6, counter and bound width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 resets immediately.
- load  input  1  synchronous parallel load; highest priority after reset.
- en  input  1  count enable; decrements only in RUN.
- par_load  input  N  load value; also captured into the reload register.
- lower_bound  input  N  terminal value; may change at any time.
- ack  input  1  clears done and leaves DONE.
- auto_reload  input  1  on ack, restart from reload register (macro-gated).
- W  output  N  registered count.
- bo  output  1  combinational, (W == lower_bound); state-independent.
- busy  output  1  registered, 1 exactly in RUN.
- done  output  1  registered, 1 exactly in DONE.

Behaviour:
- Reset (reset=0, async):
  - W=0, reload_reg=0, state=IDLE, busy=0, done=0.
  - bo follows (0 == lower_bound).
  - Reset mid-operation aborts immediately with no further edge needed.
- Priority on each edge: load > ack > en.
- load, in any state:
  - W<=par_load and reload_reg<=par_load.
  - Next state RUN if par_load > lower_bound, else DONE.
  - W is never altered by the bound check.
- IDLE:
  - en and ack ignored; W holds.
- RUN, en=1:
  - If W > lower_bound: W<=W-1. If W-1 == lower_bound, enter DONE on the same edge, so done=1 with W==lower_bound.
  - If W <= lower_bound (bound raised mid-run): W holds and next state is DONE.
- RUN, en=0:
  - W holds.
  - If W <= lower_bound, still enter DONE on the next edge.
- W never wraps below 0 or below lower_bound in RUN; there is no underflow path.
- DONE:
  - done=1, W holds, en ignored.
  - ack=1 without auto-reload: next state IDLE, W holds.
  - ack=1 with auto-reload: W<=reload_reg; next state RUN if reload_reg > lower_bound, else stay DONE.
- Latency:
  - load to busy/done: 1 edge.
  - Final decrement to done: same edge.
  - ack to done=0: 1 edge.
- Simultaneous events:
  - load and ack in DONE: load wins, ack is dropped.
  - load and en in RUN: load wins, with no decrement that cycle.
- Arithmetic: all compares unsigned, N bits.

Optional Feature:
- Macro: DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined: auto_reload is honoured on ack as described in DONE.
- Undefined:
  - auto_reload is ignored and reload_reg is not synthesised.
  - ack in DONE always goes to IDLE with W held.
- The port list is identical in both builds.

Test Plan:
- N=6, par_load=10, lower_bound=3, load pulse then en=1 steady -> busy=1 next edge, W=10,9,...,4,3; done=1 and bo=1 on the edge W becomes 3; W stays 3 with en still high.
- RUN at W=20, reset driven 0 between edges -> W=0, busy=0, done=0 before next clk; W stays 0 after release until load.
- RUN at W=7, en=1 and load=1 with par_load=15 -> W=15, still RUN; separately in DONE, load=1, ack=1, par_load=9 -> W=9, busy=1, done=0.
- RUN at W=8, en=0, lower_bound changed 3->12 -> next edge DONE, W=8, bo=0; then ack -> IDLE, W=8.
- load with par_load=5, lower_bound=5 -> DONE directly, done=1, bo=1, busy never 1.
- Macro defined, auto_reload=1, par_load=5, lower_bound=0 -> done after 5 en cycles; ack -> W=5, busy=1; same sequence with macro undefined -> IDLE, W=0.
